instr_enc: RTL and testbench
============================

# instr_enc

Instruction encoder and instruction-memory writer: the inverse of the core's immediate-generation path. It accepts decoded instruction fields (format, opcode, functs, registers, signed 32-bit immediate), packs them into a 32-bit RV32I word, and writes the words sequentially into instruction memory through a write/ack handshake. It sits beside the core's fetch path and is used to load test programs or self-modifying boot sequences into IMEM before or between runs.

## Interface
- IMEM_AW, 8, IMEM word-address width; capacity is 2^IMEM_AW words
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6/7 illegal
- in_opcode  in  7;  in_funct3  in  3;  in_funct7  in  7
- in_rd, in_rs1, in_rs2  in  5 each
- in_imm  in  32  signed byte-offset/immediate
- clr  in  1  reset write address and count
- wr_en  out  1  IMEM write request
- wr_addr  out  IMEM_AW  word address
- wr_data  out  32  encoded instruction
- wr_ack  in  1  IMEM accepted write this cycle
- count  out  IMEM_AW+1  words written since reset/clr
- full  out  1  count == 2^IMEM_AW
- err  out  1  sticky: at least one bundle rejected

## Operation
- States: IDLE, WRITE, FULL. Reset -> IDLE, count=0, wr_en=0, wr_addr=0, wr_data=0, err=0, full=0, in_ready=0 while rst high.
- in_ready = (state==IDLE) and not rst.
- IDLE, in_valid: bundle consumed. If legal: register wr_data, go WRITE. If rejected: err<=1, stay IDLE, no write, count unchanged.
- WRITE: wr_en=1, wr_addr=count[IMEM_AW-1:0], wr_data stable. On wr_ack: count+1; if new count==2^IMEM_AW go FULL else IDLE.
- FULL: in_ready=0, full=1; only clr or rst exits (to IDLE, count=0).
- clr in IDLE/FULL: count<=0, full<=0, next state IDLE; err NOT cleared (rst only). clr in WRITE ignored; clr with in_valid in IDLE: clr wins, bundle not consumed.
- Packing: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}. Unused fields ignored.
- Illegal in_fmt (6/7): always rejected.

## Timing
- Accept at edge N; wr_en high from cycle N+1; wr_ack sampled same cycle as wr_en.
- Ack at edge M: wr_en low and in_ready high from M+1. Max throughput 1 word / 2 cycles.
- No wr_ack: WRITE held indefinitely, outputs stable.
- rst in any state, including mid-WRITE: wr_en low next cycle, pending word discarded.

## Configuration
- INSTR_ENC_RANGECHK_EN defined: immediates range/alignment checked, violations rejected: I/S in [-2048,2047]; B in [-4096,4094] and even; J in [-2^20, 2^20-2] and even; U imm[11:0]==0.
- Undefined: immediates silently truncated per packing; only illegal in_fmt rejected.

## Structure
- instr_enc_pkg: format codes FMT_R..FMT_J, opcode constants (OP_LOAD 0x03, OP_STORE 0x23, OP_BRANCH 0x63, OP_LUI 0x37, OP_JAL 0x6F, OP_IMM 0x13, OP_OP 0x33), state enum.
- Sub-module instr_pack: combinational fields->word plus legal flag; instr_enc holds FSM, counter, registers.

## Test plan
- lw x5,8(x2): fmt I, op 0x03, f3 2, rd 5, rs1 2, imm 8 -> wr_data 0x00812283, wr_addr 0, count 1 after ack.
- sw x6,-4(x2): fmt S, op 0x23, f3 2, rs1 2, rs2 6, imm -4 -> 0xFE612E23 at addr 1.
- beq x0,x0,-8: fmt B, op 0x63, f3 0, imm -8 -> 0xFE000CE3.
- lw x5,2048(x2): with macro -> no wr_en, err=1, count unchanged; without -> 0x80012283 written.
- wr_ack low 3 cycles -> wr_en/addr/data stable, in_ready 0; ack -> in_ready 1 next cycle; rst mid-WRITE -> wr_en 0, count 0.
- IMEM_AW=2: four writes -> full=1, in_ready 0, in_valid ignored; clr -> count 0, full 0, in_ready 1, err unchanged.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - format codes, opcode constants and FSM states for instr_enc
package instr_enc_pkg;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_OP     = 7'h33;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational RV32I field packer with legality flag
// INSTR_ENC_RANGECHK_EN enables immediate range/alignment checking.
module instr_pack
   import instr_enc_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        legal
);

`ifdef INSTR_ENC_RANGECHK_EN
   logic signed [31:0] simm;
   assign simm = imm;
`endif

   always_comb begin
      word  = 32'd0;
      legal = 1'b1;
      case (fmt)
         FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef INSTR_ENC_RANGECHK_EN
            legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
`endif
         end
         FMT_S: begin
            word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef INSTR_ENC_RANGECHK_EN
            legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
`endif
         end
         FMT_B: begin
            word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef INSTR_ENC_RANGECHK_EN
            legal = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
`endif
         end
         FMT_U: begin
            word = {imm[31:12], rd, opcode};
`ifdef INSTR_ENC_RANGECHK_EN
            legal = (imm[11:0] == 12'd0);
`endif
         end
         FMT_J: begin
            word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef INSTR_ENC_RANGECHK_EN
            legal = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
`endif
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_enc.sv
// rtl/instr_enc.sv - instruction encoder and sequential IMEM writer
// INSTR_ENC_RANGECHK_EN (see instr_pack) rejects out-of-range immediates.
module instr_enc
   import instr_enc_pkg::*;
#(
   parameter int IMEM_AW = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_fmt,
   input  logic [6:0]         in_opcode,
   input  logic [2:0]         in_funct3,
   input  logic [6:0]         in_funct7,
   input  logic [4:0]         in_rd,
   input  logic [4:0]         in_rs1,
   input  logic [4:0]         in_rs2,
   input  logic [31:0]        in_imm,
   input  logic               clr,
   output logic               wr_en,
   output logic [IMEM_AW-1:0] wr_addr,
   output logic [31:0]        wr_data,
   input  logic               wr_ack,
   output logic [IMEM_AW:0]   count,
   output logic               full,
   output logic               err
);

   localparam logic [IMEM_AW:0] CAPACITY = {1'b1, {IMEM_AW{1'b0}}};

   state_t             state;
   state_t             state_nxt;
   logic [IMEM_AW:0]   count_q;
   logic [IMEM_AW:0]   count_inc;
   logic [31:0]        data_q;
   logic               err_q;
   logic [31:0]        packed_word;
   logic               packed_legal;
   logic               take;

   instr_pack u_pack (
      .fmt    (in_fmt),
      .opcode (in_opcode),
      .funct3 (in_funct3),
      .funct7 (in_funct7),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .imm    (in_imm),
      .word   (packed_word),
      .legal  (packed_legal)
   );

   // clr has priority over a simultaneous bundle in IDLE
   assign take      = (state == ST_IDLE) && in_valid && !clr;
   assign count_inc = count_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (take && packed_legal) state_nxt = ST_WRITE;
         ST_WRITE: if (wr_ack) state_nxt = (count_inc == CAPACITY) ? ST_FULL : ST_IDLE;
         ST_FULL:  if (clr) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_en    = (state == ST_WRITE);
      full     = (state == ST_FULL);
      in_ready = (state == ST_IDLE) && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         data_q  <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (take) begin
            if (packed_legal) data_q <= packed_word;
            else              err_q  <= 1'b1;
         end
         if (state == ST_WRITE && wr_ack)
            count_q <= count_inc;
         else if (clr && (state == ST_IDLE || state == ST_FULL))
            count_q <= '0;
      end
   end

   assign wr_addr = count_q[IMEM_AW-1:0];
   assign wr_data = data_q;
   assign count   = count_q;
   assign err     = err_q;

endmodule

// File: tb/tb_instr_enc.sv
// tb/tb_instr_enc.sv - table-driven and randomized self-checking bench for instr_enc
module tb_instr_enc;

   localparam int AW  = 2;
   localparam int CAP = 1 << AW;
`ifdef INSTR_ENC_RANGECHK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] word;
      bit          rc_bad;
      bit          fmt_bad;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, clr, wr_en, wr_ack, full, err;
   logic [2:0]    in_fmt, in_funct3;
   logic [6:0]    in_opcode, in_funct7;
   logic [4:0]    in_rd, in_rs1, in_rs2;
   logic [31:0]   in_imm, wr_data;
   logic [AW-1:0] wr_addr;
   logic [AW:0]   count;

   int vectors = 0;
   int miscompares = 0;
   int mcount;
   bit merr;
   vec_t tbl [15];

   always #5 clk = ~clk;

   instr_enc #(.IMEM_AW(AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .count(count), .full(full), .err(err)
   );

   task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s/%s: got %h expected %h", tag, what, act, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input vec_t v);
      logic [31:0] op, rd, f3, f7, rs1, rs2, imm;
      op = 32'(v.op); rd = 32'(v.rd); f3 = 32'(v.f3); f7 = 32'(v.f7);
      rs1 = 32'(v.rs1); rs2 = 32'(v.rs2); imm = v.imm;
      case (v.fmt)
         3'd0: return op | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
         3'd1: return op | rd << 7 | f3 << 12 | rs1 << 15 | (imm & 32'hFFF) << 20;
         3'd2: return op | (imm & 32'd31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20
                      | ((imm >> 5) & 32'd127) << 25;
         3'd3: return op | ((imm >> 11) & 32'd1) << 7 | ((imm >> 1) & 32'd15) << 8 | f3 << 12
                      | rs1 << 15 | rs2 << 20 | ((imm >> 5) & 32'd63) << 25 | ((imm >> 12) & 32'd1) << 31;
         3'd4: return op | rd << 7 | (imm & 32'hFFFFF000);
         3'd5: return op | rd << 7 | ((imm >> 12) & 32'd255) << 12 | ((imm >> 11) & 32'd1) << 20
                      | ((imm >> 1) & 32'd1023) << 21 | ((imm >> 20) & 32'd1) << 31;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit model_legal(input vec_t v);
      int s;
      s = int'(v.imm);
      if (v.fmt > 3'd5) return 1'b0;
      if (!RC) return 1'b1;
      case (v.fmt)
         3'd1, 3'd2: return s >= -2048 && s <= 2047;
         3'd3:       return s >= -4096 && s <= 4094 && v.imm[0] == 1'b0;
         3'd4:       return v.imm[11:0] == 12'd0;
         3'd5:       return s >= -(1 << 20) && s <= (1 << 20) - 2 && v.imm[0] == 1'b0;
         default:    return 1'b1;
      endcase
   endfunction

   task automatic drive(input vec_t v);
      in_fmt = v.fmt; in_opcode = v.op; in_funct3 = v.f3; in_funct7 = v.f7;
      in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
   endtask

   task automatic accept_edge(input vec_t v);
      drive(v);
      in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send(input vec_t v, input bit legal, input int ack_delay, input string tag);
      accept_edge(v);
      if (legal) begin
         chk(tag, "wr_en", 32'(wr_en), 32'd1);
         chk(tag, "wr_data", wr_data, v.word);
         chk(tag, "wr_addr", 32'(wr_addr), 32'(mcount % CAP));
         chk(tag, "in_ready_busy", 32'(in_ready), 32'd0);
         for (int k = 0; k < ack_delay; k++) begin
            @(posedge clk); @(negedge clk);
            chk(tag, "stall_wr_en", 32'(wr_en), 32'd1);
            chk(tag, "stall_wr_data", wr_data, v.word);
            chk(tag, "stall_wr_addr", 32'(wr_addr), 32'(mcount % CAP));
         end
         wr_ack = 1'b1;
         @(posedge clk); @(negedge clk);
         wr_ack = 1'b0;
         mcount++;
         chk(tag, "wr_en_after_ack", 32'(wr_en), 32'd0);
         chk(tag, "count", 32'(count), 32'(mcount));
         chk(tag, "full", 32'(full), 32'(mcount == CAP));
         chk(tag, "in_ready", 32'(in_ready), 32'(mcount != CAP));
         chk(tag, "err", 32'(err), 32'(merr));
      end else begin
         merr = 1'b1;
         chk(tag, "rej_wr_en", 32'(wr_en), 32'd0);
         chk(tag, "rej_err", 32'(err), 32'd1);
         chk(tag, "rej_count", 32'(count), 32'(mcount));
         chk(tag, "rej_in_ready", 32'(in_ready), 32'd1);
      end
   endtask

   task automatic do_clr(input string tag);
      clr = 1'b1;
      @(posedge clk); @(negedge clk);
      clr = 1'b0;
      mcount = 0;
      chk(tag, "clr_count", 32'(count), 32'd0);
      chk(tag, "clr_full", 32'(full), 32'd0);
      chk(tag, "clr_in_ready", 32'(in_ready), 32'd1);
      chk(tag, "clr_err", 32'(err), 32'(merr));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      bit   legal;
      tbl[0]  = '{3'd1, 7'h03, 3'd2, 7'd0, 5'd5, 5'd2, 5'd0, 32'h00000008, 32'h00812283, 1'b0, 1'b0};
      tbl[1]  = '{3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd6, 32'hFFFFFFFC, 32'hFE612E23, 1'b0, 1'b0};
      tbl[2]  = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 32'hFE000CE3, 1'b0, 1'b0};
      tbl[3]  = '{3'd1, 7'h03, 3'd2, 7'd0, 5'd5, 5'd2, 5'd0, 32'h00000800, 32'h80012283, 1'b1, 1'b0};
      tbl[4]  = '{3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h00000000, 32'h002081B3, 1'b0, 1'b0};
      tbl[5]  = '{3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 32'h123450B7, 1'b0, 1'b0};
      tbl[6]  = '{3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0, 1'b0};
      tbl[7]  = '{3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
      tbl[8]  = '{3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'h00000004, 32'h00000000, 1'b0, 1'b1};
      tbl[9]  = '{3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00001FFF, 32'h000010B7, 1'b1, 1'b0};
      tbl[10] = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h00000003, 32'h00000163, 1'b1, 1'b0};
      tbl[11] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0, 1'b0};
      tbl[12] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF7FF, 32'h7FF00093, 1'b1, 1'b0};
      tbl[13] = '{3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFF00000, 32'h800000EF, 1'b0, 1'b0};
      tbl[14] = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h00000FFE, 32'h7E000FE3, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; clr = 1'b0; wr_ack = 1'b0;
      drive(tbl[0]);
      repeat (2) @(negedge clk);
      chk("reset", "wr_en", 32'(wr_en), 32'd0);
      chk("reset", "wr_addr", 32'(wr_addr), 32'd0);
      chk("reset", "wr_data", wr_data, 32'd0);
      chk("reset", "count", 32'(count), 32'd0);
      chk("reset", "err", 32'(err), 32'd0);
      chk("reset", "full", 32'(full), 32'd0);
      chk("reset", "in_ready_in_rst", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("reset", "in_ready_after", 32'(in_ready), 32'd1);
      mcount = 0; merr = 1'b0;

      for (int i = 0; i < 15; i++) begin
         if (mcount == CAP) do_clr("tbl");
         legal = !tbl[i].fmt_bad && !(RC && tbl[i].rc_bad);
         send(tbl[i], legal, i % 3, $sformatf("tbl%0d", i));
      end

      if (mcount == CAP) do_clr("stall");
      send(tbl[0], 1'b1, 3, "stall3");

      // reset while a write is pending discards it
      if (mcount == CAP) do_clr("rstmid");
      accept_edge(tbl[5]);
      chk("rstmid", "wr_en_pre", 32'(wr_en), 32'd1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      mcount = 0; merr = 1'b0;
      chk("rstmid", "wr_en", 32'(wr_en), 32'd0);
      chk("rstmid", "count", 32'(count), 32'd0);
      chk("rstmid", "wr_data", wr_data, 32'd0);
      chk("rstmid", "err", 32'(err), 32'd0);

      for (int i = 0; i < CAP; i++) send(tbl[4], 1'b1, 0, "fill");
      accept_edge(tbl[4]);
      chk("full", "wr_en_ignored", 32'(wr_en), 32'd0);
      chk("full", "count_held", 32'(count), 32'(CAP));
      accept_edge(tbl[7]);
      chk("full", "err_not_set", 32'(err), 32'd0);
      chk("full", "in_ready", 32'(in_ready), 32'd0);
      do_clr("full");

      send(tbl[7], 1'b0, 0, "illegal");
      drive(tbl[0]);
      in_valid = 1'b1; clr = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; clr = 1'b0;
      mcount = 0;
      chk("clrwin", "wr_en", 32'(wr_en), 32'd0);
      chk("clrwin", "count", 32'(count), 32'd0);
      chk("clrwin", "in_ready", 32'(in_ready), 32'd1);
      chk("clrwin", "err_kept", 32'(err), 32'd1);

      for (int n = 0; n < 300; n++) begin
         if (mcount == CAP) do_clr("rand");
         v.fmt = 3'($urandom_range(0, 7));
         v.op  = 7'($urandom);  v.f3  = 3'($urandom);  v.f7 = 7'($urandom);
         v.rd  = 5'($urandom);  v.rs1 = 5'($urandom);  v.rs2 = 5'($urandom);
         case ($urandom_range(0, 2))
            0:       v.imm = $urandom;
            1:       v.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            default: v.imm = 32'(int'($urandom_range(0, (1 << 22) - 1)) - (1 << 21));
         endcase
         v.rc_bad = 1'b0; v.fmt_bad = 1'b0;
         v.word = model_word(v);
         send(v, model_legal(v), $urandom_range(0, 2), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
